// File: rtl/bundler_out.sv
// ---------------------------------------------------------------------------
// bundler_out
//   Assembles a DIMENSIONS-bit hypervector from PAR_BITS-wide majority chunks
//   produced by an upstream bundler. The chunk at offset d lands in
//   hv_out[d +: PAR_BITS]. Once the whole vector is written it is presented
//   on hv_out with hv_valid until the consumer accepts it with hv_ready.
//
// Parameters
//   DIMENSIONS  hypervector length in bits (integer multiple of PAR_BITS)
//   PAR_BITS    bits per chunk
//
// Ports
//   clk          clock, rising-edge
//   nrst         asynchronous active-low reset
//   start        request to assemble a new hypervector (IDLE, or DONE+hv_ready)
//   clear        synchronous abort to IDLE; hv_out keeps its contents
//   chunk_valid  chunk_in is valid this cycle (used only in BUNDLE)
//   chunk_in     majority bits for offset d
//   hv_ready     consumer accepts hv_out this cycle
//   state        0=IDLE, 1=BUNDLE, 2=DONE; upstream bundler enable
//   d            current chunk bit offset
//   hv_out       assembled hypervector
//   hv_valid     hv_out complete and stable (state == DONE)
// ---------------------------------------------------------------------------
module bundler_out #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned PAR_BITS   = 10
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          chunk_valid,
  input  logic [PAR_BITS-1:0]           chunk_in,
  input  logic                          hv_ready,
  output logic [1:0]                    state,
  output logic [$clog2(DIMENSIONS)-1:0] d,
  output logic [DIMENSIONS-1:0]         hv_out,
  output logic                          hv_valid
);

  localparam int unsigned DW = $clog2(DIMENSIONS);
  localparam logic [DW-1:0] D_STEP = DW'(PAR_BITS);
  localparam logic [DW-1:0] D_LAST = DW'(DIMENSIONS - PAR_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUNDLE  = 2'd1,
    DONE    = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [DW-1:0]   d_n;
  logic            wr_en;

  // Next-state, next-offset and chunk write enable.
  always_comb begin
    state_n = state_q;
    d_n     = d;
    wr_en   = 1'b0;
    if (clear) begin
      state_n = IDLE;
      d_n     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_n = BUNDLE;
            d_n     = '0;
          end
        end
        BUNDLE: begin
          if (chunk_valid) begin
            wr_en = 1'b1;
            if (d == D_LAST) begin
              state_n = DONE;
              d_n     = '0;
            end else begin
              d_n = d + D_STEP;
            end
          end
        end
        DONE: begin
          // start only counts when the finished vector is accepted, which
          // allows back-to-back vectors without an IDLE bubble.
          if (hv_ready) begin
            state_n = start ? BUNDLE : IDLE;
            d_n     = '0;
          end
        end
        default: begin
          state_n = IDLE;
          d_n     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      d        <= '0;
      hv_out   <= '0;
      hv_valid <= 1'b0;
    end else begin
      state_q  <= state_n;
      d        <= d_n;
      // Registered copy of (state == DONE) so hv_valid rises on the same
      // edge that writes the last chunk.
      hv_valid <= (state_n == DONE);
      if (wr_en) begin
        hv_out[d +: PAR_BITS] <= chunk_in;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bundler_out.sv
module tb_bundler_out;

  localparam int unsigned DIM = 40;
  localparam int unsigned PB  = 10;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic          clear;
  logic          chunk_valid;
  logic [PB-1:0] chunk_in;
  logic          hv_ready;
  logic [1:0]    state;
  logic [5:0]    d;
  logic [DIM-1:0] hv_out;
  logic          hv_valid;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [DIM-1:0] exp_basic;
  logic [DIM-1:0] exp_abort;
  logic [DIM-1:0] snap;

  bundler_out #(.DIMENSIONS(DIM), .PAR_BITS(PB)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .clear      (clear),
    .chunk_valid(chunk_valid),
    .chunk_in   (chunk_in),
    .hv_ready   (hv_ready),
    .state      (state),
    .d          (d),
    .hv_out     (hv_out),
    .hv_valid   (hv_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle to a sampling point 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chunk(input logic [PB-1:0] v);
    chunk_valid = 1'b1;
    chunk_in    = v;
    step();
    chunk_valid = 1'b0;
  endtask

  initial begin
    exp_basic = {10'h155, 10'h2AA, 10'h000, 10'h3FF};
    nrst = 1'b0; start = 1'b0; clear = 1'b0; chunk_valid = 1'b0;
    chunk_in = '0; hv_ready = 1'b0;
    #2;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_hv", 64'(hv_out), 64'd0);
    chk("rst_valid", 64'(hv_valid), 64'd0);
    step(); step();
    nrst = 1'b1;

    // Chunks offered in IDLE are ignored.
    chunk_valid = 1'b1; chunk_in = 10'h3FF;
    step();
    chunk_valid = 1'b0;
    chk("idle_ign_hv", 64'(hv_out), 64'd0);
    chk("idle_ign_d", 64'(d), 64'd0);
    chk("idle_ign_state", 64'(state), 64'd0);

    // Basic assembly.
    start = 1'b1; step(); start = 1'b0;
    chk("basic_state", 64'(state), 64'd1);
    chk("basic_d0", 64'(d), 64'd0);
    chunk(10'h3FF);
    chk("basic_d10", 64'(d), 64'd10);
    chunk(10'h000);
    chunk(10'h2AA);
    chk("basic_d30", 64'(d), 64'd30);
    chk("basic_nvalid", 64'(hv_valid), 64'd0);
    chunk(10'h155);
    chk("basic_done", 64'(state), 64'd2);
    chk("basic_valid", 64'(hv_valid), 64'd1);
    chk("basic_dz", 64'(d), 64'd0);
    chk("basic_hv", 64'(hv_out), 64'(exp_basic));

    // Backpressure: start pulses and stray chunks ignored in DONE.
    for (int i = 0; i < 5; i++) begin
      start = i[0] ? 1'b0 : 1'b1;
      chunk_valid = 1'b1; chunk_in = 10'h0A5;
      step();
      chk("bp_state", 64'(state), 64'd2);
      chk("bp_valid", 64'(hv_valid), 64'd1);
      chk("bp_hv", 64'(hv_out), 64'(exp_basic));
    end
    chunk_valid = 1'b0;
    hv_ready = 1'b1; start = 1'b1;
    step();
    hv_ready = 1'b0; start = 1'b0;
    chk("b2b_state", 64'(state), 64'd1);
    chk("b2b_d", 64'(d), 64'd0);
    chk("b2b_valid", 64'(hv_valid), 64'd0);

    // Stall of three cycles between chunks 2 and 3; start ignored in BUNDLE.
    chunk(10'h3FF);
    chunk(10'h000);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_d", 64'(d), 64'd20);
      chk("stall_state", 64'(state), 64'd1);
    end
    start = 1'b0;
    chunk(10'h2AA);
    chk("stall_nvalid", 64'(hv_valid), 64'd0);
    chunk(10'h155);
    chk("stall_valid", 64'(hv_valid), 64'd1);
    chk("stall_hv", 64'(hv_out), 64'(exp_basic));
    hv_ready = 1'b1;
    step();
    hv_ready = 1'b0;
    chk("accept_state", 64'(state), 64'd0);
    chk("accept_valid", 64'(hv_valid), 64'd0);
    chk("accept_hv", 64'(hv_out), 64'(exp_basic));

    // Abort at d=20: partial chunks kept, upper bits untouched.
    start = 1'b1; step(); start = 1'b0;
    chunk(10'h0F0);
    chunk(10'h30C);
    chk("abort_d20", 64'(d), 64'd20);
    clear = 1'b1; chunk_valid = 1'b1; chunk_in = 10'h111;
    step();
    clear = 1'b0; chunk_valid = 1'b0;
    exp_abort = {10'h155, 10'h2AA, 10'h30C, 10'h0F0};
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_d", 64'(d), 64'd0);
    chk("abort_hv", 64'(hv_out), 64'(exp_abort));
    chunk(10'h1C3);
    chunk(10'h2B4);
    chk("abort_ign_hv", 64'(hv_out), 64'(exp_abort));
    chk("abort_ign_d", 64'(d), 64'd0);

    // Asynchronous reset mid-BUNDLE at d=30.
    start = 1'b1; step(); start = 1'b0;
    chunk(10'h001);
    chunk(10'h002);
    chunk(10'h003);
    chk("ar_d30", 64'(d), 64'd30);
    #2;
    nrst = 1'b0;
    #1;
    chk("ar_state", 64'(state), 64'd0);
    chk("ar_d", 64'(d), 64'd0);
    chk("ar_hv", 64'(hv_out), 64'd0);
    chk("ar_valid", 64'(hv_valid), 64'd0);
    step();
    nrst = 1'b1;
    snap = hv_out;
    chunk(10'h3FF);
    step();
    chk("ar_idle_state", 64'(state), 64'd0);
    chk("ar_idle_hv", 64'(hv_out), 64'(snap));
    start = 1'b1; step(); start = 1'b0;
    chk("ar_restart", 64'(state), 64'd1);
    chk("ar_restart_d", 64'(d), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
